// File: rtl/seg_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver: shadows a packed nibble value on a load strobe,
// scans the digits with a fixed dwell, and applies leading-zero blanking, decimal points and blinking.
module seg_scan_driver #(
   parameter int DIGITS         = 4,
   parameter int SCAN_DIV       = 50000,
   parameter int BLINK_HALF     = 25000000,
   parameter int HEX_EN         = 0,
   parameter int SEG_ACTIVE_LOW = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   num,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     blink_in,
   input  logic                  load,
   input  logic                  lzb,
   output logic [6:0]            code,
   output logic                  dp,
   output logic [DIGITS-1:0]     dig_sel
);

   localparam int SCAN_W  = $clog2(SCAN_DIV);
   localparam int BLINK_W = $clog2(BLINK_HALF);
   localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   // XOR masks that turn an active-high pattern into the pin polarity.
   localparam logic [6:0] SEG_POL = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
   localparam logic       DP_POL  = (SEG_ACTIVE_LOW != 0);

   logic [4*DIGITS-1:0] shadow_num;
   logic [DIGITS-1:0]   shadow_dp;
   logic [DIGITS-1:0]   shadow_blink;
   logic [SCAN_W-1:0]   scan_cnt;
   logic [IDX_W-1:0]    idx;
   logic [BLINK_W-1:0]  blink_cnt;
   logic                phase;

   logic [DIGITS-1:0]   upper_zero;
   logic [3:0]          cur_nib;
   logic                cur_dp;
   logic                cur_blink;
   logic                cur_lz;
   logic [DIGITS-1:0]   sel_n;
   logic [6:0]          seg_raw;
   logic                blink_blank;
   logic [6:0]          seg_act;
   logic                dp_act;

   function automatic logic [6:0] decode(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'b0111111;
         4'h1: s = 7'b0000110;
         4'h2: s = 7'b1011011;
         4'h3: s = 7'b1001111;
         4'h4: s = 7'b1100110;
         4'h5: s = 7'b1101101;
         4'h6: s = 7'b1111101;
         4'h7: s = 7'b0000111;
         4'h8: s = 7'b1111111;
         4'h9: s = 7'b1101111;
         4'hA: s = 7'b1110111;
         4'hB: s = 7'b1111100;
         4'hC: s = 7'b0111001;
         4'hD: s = 7'b1011110;
         4'hE: s = 7'b1111001;
         default: s = 7'b1110001;
      endcase
      if (HEX_EN == 0 && nib > 4'd9) s = 7'b0000000;
      return s;
   endfunction

   // upper_zero[i]: this digit and every more-significant digit hold zero.
   for (genvar g = 0; g < DIGITS; g++) begin : g_lz
      assign upper_zero[g] = (shadow_num[4*DIGITS-1:4*g] == '0);
   end

   always_comb begin
      cur_nib   = 4'd0;
      cur_dp    = 1'b0;
      cur_blink = 1'b0;
      cur_lz    = 1'b0;
      sel_n     = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_nib   = shadow_num[4*i +: 4];
            cur_dp    = shadow_dp[i];
            cur_blink = shadow_blink[i];
            cur_lz    = lzb && (i != 0) && upper_zero[i];
            sel_n[i]  = 1'b0;
         end
      end
   end

   assign seg_raw     = decode(cur_nib);
   assign blink_blank = cur_blink && phase;
   // Leading-zero blanking hides the segments only; the decimal point survives it.
   assign seg_act     = (cur_lz || blink_blank) ? 7'b0000000 : seg_raw;
   assign dp_act      = cur_dp && !blink_blank;

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_num   <= '0;
         shadow_dp    <= '0;
         shadow_blink <= '0;
         scan_cnt     <= '0;
         idx          <= '0;
         blink_cnt    <= '0;
         phase        <= 1'b0;
         code         <= SEG_POL;
         dp           <= DP_POL;
         dig_sel      <= '1;
      end else begin
         if (load) begin
            shadow_num   <= num;
            shadow_dp    <= dp_in;
            shadow_blink <= blink_in;
         end

         if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            if (idx == IDX_W'(DIGITS - 1)) idx <= '0;
            else                           idx <= idx + 1'b1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end

         if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end

         code    <= seg_act ^ SEG_POL;
         dp      <= dp_act ^ DP_POL;
         dig_sel <= sel_n;
      end
   end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised multi-digit 7-segment display driver that replaces per-digit decoders with one time-multiplexed engine. It latches a packed BCD/hex value on a load strobe, scans DIGITS digits with a programmable dwell time, and decodes each nibble to segments. It also provides leading-zero blanking, per-digit decimal points and per-digit blinking. It sits between the score/timer logic and the board's display pins.

## Interface
- DIGITS, 4, number of digits scanned (1–8)
- SCAN_DIV, 50000, clk cycles each digit stays selected (≥2)
- BLINK_HALF, 25000000, clk cycles per blink half-period (≥2)
- HEX_EN, 0, 1 = decode 0–F; 0 = decode 0–9, nibbles 10–15 blank
- SEG_ACTIVE_LOW, 0, 1 = invert seg and dp at the output register
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- num  in  4*DIGITS  packed nibbles; num[3:0] = digit 0 (least significant)
- dp_in  in  DIGITS  decimal-point request per digit
- blink_in  in  DIGITS  blink enable per digit
- load  in  1  one-cycle strobe; captures num, dp_in, blink_in into shadow
- lzb  in  1  leading-zero blanking enable (live, not shadowed)
- code  out  7  segments {g,f,e,d,c,b,a}, registered
- dp  out  1  decimal-point segment, registered
- dig_sel  out  DIGITS  one-hot active-low digit enable, registered

## Operation
- Reset (rst high at an edge): shadow value, dp and blink cleared to 0; scan_cnt=0; idx=0; blink_cnt=0; phase=0; code=blank, dp=off, dig_sel=all 1.
- Shadow: when load=1, shadow takes num/dp_in/blink_in at that edge. Without load, shadow holds. A load that coincides with rst is ignored.
- Scan: scan_cnt counts 0..SCAN_DIV-1. At the edge where scan_cnt==SCAN_DIV-1, scan_cnt goes to 0 and idx goes to idx+1, wrapping DIGITS-1 to 0.
- Blink: blink_cnt counts 0..BLINK_HALF-1. At its terminal edge, blink_cnt goes to 0 and phase toggles. Scan and blink counters are free-running and independent.
- Decode, active-high before polarity: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001. Blank=0000000.
- Leading-zero blank: with lzb=1, digit i>0 is blank when shadow nibbles i..DIGITS-1 are all zero. Digit 0 is never LZ-blanked.
- Blink blank: digit i is blank (segments and dp) when blink[i]=1 and phase=1.
- dp output = shadow dp[idx], masked by blink blank only; LZ blanking does not suppress dp.
- dig_sel stays driven (bit idx low) while the selected digit is blanked.
- Output polarity: if SEG_ACTIVE_LOW=1, code and dp are inverted, including blank. dig_sel is unaffected.

## Timing
- code, dp and dig_sel are registered every cycle from the current idx, shadow, lzb and phase. Output latency is 1 cycle from any change in those.
- First valid output is the edge after reset deasserts: dig_sel bit 0 low, showing shadow digit 0 (0 → code 0111111).
- A load at edge k updates the shadow at k. The new value is visible on outputs at edge k+1 for the currently selected digit, with no wait for the next digit slot.
- Each digit is selected for exactly SCAN_DIV cycles; a full frame is DIGITS*SCAN_DIV cycles.
- rst mid-scan takes effect at the same edge and overrides load. Outputs are blank/off for that cycle.
- DIGITS=1: idx stays 0 and dig_sel is constant 0.

## Test plan
- DIGITS=4, SCAN_DIV=4: reset, load num=16'h1234 → dig_sel cycles 1110,1101,1011,0111, 4 cycles each; code 4,3,2,1 patterns (1100110, 1001111, 1011011, 0000110) on digits 0..3.
- HEX_EN=0, load 16'h00AF with lzb=0 → digits 0,1 blank (0000000), digits 2,3 show 0111111. Repeat with HEX_EN=1 → F=1110001, A=1110111.
- lzb=1, load 16'h0050 → digits 3 and 2 blank, digit 1 = 5 (1101101), digit 0 = 0. Load 16'h0000 → only digit 0 lit.
- BLINK_HALF=16, blink_in=4'b0010, dp_in=4'b0010 → digit 1 code and dp alternate lit/blank every 16 cycles; other digits steady.
- Mid-frame: load strobe while digit 2 is selected → new digit-2 pattern appears on the next edge. Assert rst mid-scan with load high → outputs blank, dig_sel=1111, shadow=0.
- SEG_ACTIVE_LOW=1, load 16'h8888 → code=0000000 while lit; blank digits and reset state read 1111111, and dp off reads 1.
